// File: rtl/cache_controller_if.sv
// Host request/response and storage bus bundle for cache_controller.
// slave = controller view, master = host + storage view.
interface cache_controller_if #(
    parameter int unsigned NUM_ENTRIES = 16,
    parameter int unsigned KEY_WIDTH   = 16,
    parameter int unsigned VALUE_WIDTH = 64
);
    logic                   req_valid;
    logic                   req_ready;
    logic [1:0]             req_op;
    logic [KEY_WIDTH-1:0]   req_key;
    logic [VALUE_WIDTH-1:0] req_value;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [1:0]             resp_status;
    logic [VALUE_WIDTH-1:0] resp_value;
    logic                   mem_write;
    logic                   mem_select_by_index;
    logic                   mem_delete;
    logic [KEY_WIDTH-1:0]   mem_key;
    logic [VALUE_WIDTH-1:0] mem_value;
    logic [NUM_ENTRIES-1:0] mem_index;
    logic [VALUE_WIDTH-1:0] mem_value_out;
    logic [NUM_ENTRIES-1:0] mem_index_out;
    logic                   mem_hit;
    logic [NUM_ENTRIES-1:0] mem_used_entries;

    modport slave (
        input  req_valid, req_op, req_key, req_value, resp_ready,
               mem_value_out, mem_index_out, mem_hit, mem_used_entries,
        output req_ready, resp_valid, resp_status, resp_value,
               mem_write, mem_select_by_index, mem_delete, mem_key, mem_value, mem_index
    );

    modport master (
        output req_valid, req_op, req_key, req_value, resp_ready,
               mem_value_out, mem_index_out, mem_hit, mem_used_entries,
        input  req_ready, resp_valid, resp_status, resp_value,
               mem_write, mem_select_by_index, mem_delete, mem_key, mem_value, mem_index
    );
endinterface

// File: rtl/cache_controller.sv
// Key/value cache controller: IDLE -> LOOKUP -> EXEC -> RESP, one request in flight.
// Optional GET hit/miss statistics counters enabled by defining CACHE_CTRL_STATS_EN.
module cache_controller #(
    parameter int unsigned NUM_ENTRIES = 16,
    parameter int unsigned KEY_WIDTH   = 16,
    parameter int unsigned VALUE_WIDTH = 64
) (
    input  logic clk,
    input  logic rst,
    cache_controller_if.slave bus
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);
    localparam logic [1:0] OP_GET = 2'd0;
    localparam logic [1:0] OP_PUT = 2'd1;
    localparam logic [1:0] OP_DEL = 2'd2;
    localparam logic [1:0] OP_ILL = 2'd3;

    localparam logic [1:0] ST_OK   = 2'd0;
    localparam logic [1:0] ST_MISS = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    typedef enum logic [1:0] {IDLE = 2'd0, LOOKUP = 2'd1, EXEC = 2'd2, RESP = 2'd3} state_t;

    state_t                 state;
    logic [1:0]             op_q;
    logic [KEY_WIDTH-1:0]   key_q;
    logic [VALUE_WIDTH-1:0] val_q;
    logic [VALUE_WIDTH-1:0] rdata_q;
    logic                   hit_q;
    logic [NUM_ENTRIES-1:0] used_q;

    logic                   req_err_c;
    logic [NUM_ENTRIES-1:0] free_now_c;
    logic [NUM_ENTRIES-1:0] free_q_c;
    logic [1:0]             exec_status_c;
    logic [VALUE_WIDTH-1:0] exec_value_c;

    // One-hot of the lowest clear bit; zero when every slot is occupied.
    function automatic logic [NUM_ENTRIES-1:0] lowest_free(input logic [NUM_ENTRIES-1:0] used);
        return ~used & (used + NUM_ENTRIES'(1));
    endfunction

    assign req_err_c  = (key_q == '0) || (op_q == OP_ILL);
    assign free_now_c = lowest_free(bus.mem_used_entries);
    assign free_q_c   = lowest_free(used_q);

    always_comb begin
        exec_status_c = ST_OK;
        exec_value_c  = '0;
        if (req_err_c) begin
            exec_status_c = ST_ERR;
        end else begin
            case (op_q)
                OP_GET: begin
                    if (hit_q) exec_value_c  = rdata_q;
                    else       exec_status_c = ST_MISS;
                end
                OP_PUT:  if (!hit_q && (free_q_c == '0)) exec_status_c = ST_FULL;
                OP_DEL:  if (!hit_q) exec_status_c = ST_MISS;
                default: exec_status_c = ST_ERR;
            endcase
        end
    end

    // Storage strobes are launched at the LOOKUP->EXEC edge so they are
    // registered, single-cycle and confined to EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                   <= IDLE;
            op_q                    <= '0;
            key_q                   <= '0;
            val_q                   <= '0;
            rdata_q                 <= '0;
            hit_q                   <= 1'b0;
            used_q                  <= '0;
            bus.req_ready           <= 1'b1;
            bus.resp_valid          <= 1'b0;
            bus.resp_status         <= '0;
            bus.resp_value          <= '0;
            bus.mem_write           <= 1'b0;
            bus.mem_select_by_index <= 1'b0;
            bus.mem_delete          <= 1'b0;
            bus.mem_key             <= '0;
            bus.mem_value           <= '0;
            bus.mem_index           <= '0;
        end else begin
            bus.mem_select_by_index <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        op_q          <= bus.req_op;
                        key_q         <= bus.req_key;
                        val_q         <= bus.req_value;
                        bus.mem_key   <= bus.req_key;
                        bus.mem_value <= bus.req_value;
                        bus.req_ready <= 1'b0;
                        state         <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    hit_q   <= bus.mem_hit;
                    rdata_q <= bus.mem_value_out;
                    used_q  <= bus.mem_used_entries;
                    if (!req_err_c) begin
                        if (op_q == OP_PUT) begin
                            if (bus.mem_hit) begin
                                bus.mem_write <= 1'b1;
                                bus.mem_index <= bus.mem_index_out;
                            end else if (free_now_c != '0) begin
                                bus.mem_write <= 1'b1;
                                bus.mem_index <= free_now_c;
                            end
                        end else if ((op_q == OP_DEL) && bus.mem_hit) begin
                            bus.mem_delete <= 1'b1;
                            bus.mem_index  <= bus.mem_index_out;
                        end
                    end
                    state <= EXEC;
                end
                EXEC: begin
                    bus.mem_write   <= 1'b0;
                    bus.mem_delete  <= 1'b0;
                    bus.mem_index   <= '0;
                    bus.mem_key     <= '0;
                    bus.mem_value   <= '0;
                    bus.resp_valid  <= 1'b1;
                    bus.resp_status <= exec_status_c;
                    bus.resp_value  <= exec_value_c;
                    state           <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid  <= 1'b0;
                        bus.resp_status <= '0;
                        bus.resp_value  <= '0;
                        bus.req_ready   <= 1'b1;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_CTRL_STATS_EN
    // Saturating GET hit/miss counters, bumped on the response handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if ((state == RESP) && bus.resp_ready && (op_q == OP_GET)) begin
            if ((bus.resp_status == ST_OK) && (hit_count != 16'hFFFF))
                hit_count <= hit_count + 16'd1;
            if ((bus.resp_status == ST_MISS) && (miss_count != 16'hFFFF))
                miss_count <= miss_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a 4-slot storage model.
module tb_cache_controller;
    localparam int unsigned NE = 4;
    localparam int unsigned KW = 16;
    localparam int unsigned VW = 64;

    localparam logic [1:0] GET = 2'd0, PUT = 2'd1, DEL = 2'd2, ILL = 2'd3;
    localparam logic [1:0] OK = 2'd0, MISS = 2'd1, FULL = 2'd2, ERR = 2'd3;

    logic clk;
    logic rst;
    logic mem_clr;
    int   total;
    int   bad;

    cache_controller_if #(.NUM_ENTRIES(NE), .KEY_WIDTH(KW), .VALUE_WIDTH(VW)) bus ();

`ifdef CACHE_CTRL_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    cache_controller #(.NUM_ENTRIES(NE), .KEY_WIDTH(KW), .VALUE_WIDTH(VW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef CACHE_CTRL_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Storage model: key-match lookup, index-addressed write/delete.
    logic [KW-1:0] m_key [NE];
    logic [VW-1:0] m_val [NE];
    logic [NE-1:0] m_used;

    always_comb begin
        bus.mem_hit       = 1'b0;
        bus.mem_index_out = '0;
        bus.mem_value_out = '0;
        for (int i = 0; i < NE; i++) begin
            if (m_used[i] && (m_key[i] == bus.mem_key)) begin
                bus.mem_hit          = 1'b1;
                bus.mem_index_out[i] = 1'b1;
                bus.mem_value_out    = m_val[i];
            end
        end
        bus.mem_used_entries = m_used;
    end

    always_ff @(posedge clk) begin
        if (mem_clr) begin
            m_used <= '0;
        end else begin
            for (int i = 0; i < NE; i++) begin
                if (bus.mem_write && bus.mem_index[i]) begin
                    m_used[i] <= 1'b1;
                    m_key[i]  <= bus.mem_key;
                    m_val[i]  <= bus.mem_value;
                end else if (bus.mem_delete && bus.mem_index[i]) begin
                    m_used[i] <= 1'b0;
                end
            end
        end
    end

    // Strobe monitor: pulse counts and one-hot / exclusivity violations.
    int n_wr, n_del, n_bad;
    initial begin n_wr = 0; n_del = 0; n_bad = 0; end
    always @(negedge clk) begin
        if (bus.mem_write) n_wr++;
        if (bus.mem_delete) n_del++;
        if ((bus.mem_write && bus.mem_delete) ||
            ((bus.mem_write || bus.mem_delete) && !$onehot(bus.mem_index)) ||
            (!(bus.mem_write || bus.mem_delete) && (bus.mem_index != '0)))
            n_bad++;
    end

    // Per-transaction observations filled by run().
    logic          t_ready, t_busy, e_wr, e_del, e_sel, e_rv;
    logic [NE-1:0] e_idx;
    logic [KW-1:0] e_key;
    logic [VW-1:0] e_val;
    logic          r_valid, a_valid, a_ready;
    logic [1:0]    r_status;
    logic [VW-1:0] r_value;
    int            d_wr, d_del, d_bad, hold_bad, hold_rdy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [1:0] op, input logic [KW-1:0] key,
                       input logic [VW-1:0] val, input int hold);
        int w0, d0, b0, guard;
        w0 = n_wr; d0 = n_del; b0 = n_bad; guard = 0;
        while (!bus.req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
        t_ready        = bus.req_ready;
        bus.req_valid  = 1'b1;
        bus.req_op     = op;
        bus.req_key    = key;
        bus.req_value  = val;
        bus.resp_ready = (hold == 0);
        @(posedge clk); #1;                      // T+1 LOOKUP
        bus.req_valid = 1'b0;
        t_busy = bus.req_ready;
        @(posedge clk); #1;                      // T+2 EXEC
        e_wr = bus.mem_write; e_del = bus.mem_delete; e_sel = bus.mem_select_by_index;
        e_idx = bus.mem_index; e_key = bus.mem_key; e_val = bus.mem_value;
        e_rv = bus.resp_valid;
        @(posedge clk); #1;                      // T+3 RESP
        r_valid = bus.resp_valid; r_status = bus.resp_status; r_value = bus.resp_value;
        hold_bad = 0; hold_rdy = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if ((bus.resp_valid !== r_valid) || (bus.resp_status !== r_status) ||
                (bus.resp_value !== r_value)) hold_bad++;
            if (bus.req_ready !== 1'b0) hold_rdy++;
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        a_valid = bus.resp_valid; a_ready = bus.req_ready;
        d_wr = n_wr - w0; d_del = n_del - d0; d_bad = n_bad - b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; mem_clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_mem_write", bus.mem_write, 0);
        chk("rst_mem_index", bus.mem_index, 0);
        rst = 1'b0; mem_clr = 1'b0;
        #1;
        chk("rst_req_ready", bus.req_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    int w_snap;

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; mem_clr = 1'b1;
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_key = '0; bus.req_value = '0;
        bus.resp_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst0_resp_valid", bus.resp_valid, 0);
        chk("rst0_resp_status", bus.resp_status, 0);
        chk("rst0_mem_delete", bus.mem_delete, 0);
        chk("rst0_mem_key", bus.mem_key, 0);
        rst = 1'b0; mem_clr = 1'b0;
        #1;
        chk("rst0_req_ready", bus.req_ready, 1);

        // PUT on empty cache lands in slot 0
        run(PUT, 16'h0011, 64'hAA, 0);
        chk("put1_ready", t_ready, 1);
        chk("put1_busy", t_busy, 0);
        chk("put1_wr", e_wr, 1);
        chk("put1_idx", e_idx, 4'b0001);
        chk("put1_key", e_key, 16'h0011);
        chk("put1_val", e_val, 64'hAA);
        chk("put1_sel", e_sel, 0);
        chk("put1_exec_rv", e_rv, 0);
        chk("put1_rvalid", r_valid, 1);
        chk("put1_status", r_status, OK);
        chk("put1_value", r_value, 0);
        chk("put1_after_ready", a_ready, 1);
        chk("put1_after_valid", a_valid, 0);
        chk("put1_npulse", d_wr, 1);

        run(GET, 16'h0011, 64'h0, 0);
        chk("get_hit_status", r_status, OK);
        chk("get_hit_value", r_value, 64'hAA);
        chk("get_hit_npulse", d_wr + d_del, 0);

        run(GET, 16'h0022, 64'h0, 0);
        chk("get_miss_status", r_status, MISS);
        chk("get_miss_value", r_value, 0);
        chk("get_miss_npulse", d_wr + d_del, 0);

        // Fill all four slots
        do_reset();
        run(PUT, 16'h0033, 64'h3333, 0);
        chk("fill0_idx", e_idx, 4'b0001);
        run(PUT, 16'h0044, 64'h4444, 0);
        chk("fill1_idx", e_idx, 4'b0010);
        run(PUT, 16'h0011, 64'h1111, 0);
        chk("fill2_idx", e_idx, 4'b0100);
        run(PUT, 16'h0055, 64'h5555, 0);
        chk("fill3_idx", e_idx, 4'b1000);
        chk("fill3_status", r_status, OK);

        run(PUT, 16'h0099, 64'h9999, 0);
        chk("full_status", r_status, FULL);
        chk("full_nwr", d_wr, 0);

        run(PUT, 16'h0044, 64'hBB, 0);
        chk("overwrite_status", r_status, OK);
        chk("overwrite_idx", e_idx, 4'b0010);
        chk("overwrite_val", e_val, 64'hBB);

        run(DEL, 16'h0011, 64'h0, 0);
        chk("del_pulse", e_del, 1);
        chk("del_wr", e_wr, 0);
        chk("del_idx", e_idx, 4'b0100);
        chk("del_status", r_status, OK);
        chk("del_value", r_value, 0);

        run(DEL, 16'h0011, 64'h0, 0);
        chk("del2_status", r_status, MISS);
        chk("del2_npulse", d_wr + d_del, 0);

        // Illegal requests and response backpressure
        run(PUT, 16'h0000, 64'h1234, 0);
        chk("err_key0_status", r_status, ERR);
        chk("err_key0_npulse", d_wr + d_del, 0);

        run(ILL, 16'h0044, 64'h0, 5);
        chk("err_op3_status", r_status, ERR);
        chk("err_op3_npulse", d_wr + d_del, 0);
        chk("hold_valid", r_valid, 1);
        chk("hold_stable", hold_bad, 0);
        chk("hold_req_ready", hold_rdy, 0);
        chk("hold_release_valid", a_valid, 0);
        chk("hold_release_ready", a_ready, 1);

        // Reset during EXEC of a PUT into the free slot 2
        w_snap = n_wr;
        bus.req_valid = 1'b1; bus.req_op = PUT; bus.req_key = 16'h0077; bus.req_value = 64'h7777;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        chk("rstx_in_exec_wr", bus.mem_write, 1);
        #1 rst = 1'b1;
        #1;
        chk("rstx_wr", bus.mem_write, 0);
        chk("rstx_idx", bus.mem_index, 0);
        chk("rstx_key", bus.mem_key, 0);
        chk("rstx_resp_valid", bus.resp_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rstx_req_ready", bus.req_ready, 1);
        repeat (4) begin
            @(posedge clk); #1;
            chk("rstx_no_resp", bus.resp_valid, 0);
        end
        chk("rstx_no_commit", n_wr - w_snap, 0);

        run(GET, 16'h0077, 64'h0, 0);
        chk("rstx_get_status", r_status, MISS);

        // Exactly one free slot is used, then FULL
        run(PUT, 16'h0099, 64'h9999, 0);
        chk("last_free_status", r_status, OK);
        chk("last_free_idx", e_idx, 4'b0100);
        run(PUT, 16'h00AB, 64'hABAB, 0);
        chk("after_last_status", r_status, FULL);
        chk("after_last_nwr", d_wr, 0);

        run(GET, 16'h0033, 64'h0, 0);
        chk("get33", r_value, 64'h3333);
        run(GET, 16'h0044, 64'h0, 0);
        chk("get44", r_value, 64'hBB);
        run(GET, 16'h0099, 64'h0, 0);
        chk("get99", r_value, 64'h9999);
        run(GET, 16'h0011, 64'h0, 0);
        chk("get11_status", r_status, MISS);
        chk("strobe_violations", n_bad, 0);

`ifdef CACHE_CTRL_STATS_EN
        chk("hit_count", hit_count, 3);
        chk("miss_count", miss_count, 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 16, number of cache slots (one-hot index width).
REQ-002 SHALL have parameter KEY_WIDTH, default 16, key width in bits.
REQ-003 SHALL have parameter VALUE_WIDTH, default 64, value width in bits.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 SHALL have these ports:
- clk  in  1  rising-edge clock.
- rst  in  1  async active-high reset.
- req_valid  in  1  host request valid.
- req_ready  out  1  controller accepts a request.
- req_op  in  2  0=GET, 1=PUT, 2=DEL, 3=illegal.
- req_key  in  KEY_WIDTH  request key.
- req_value  in  VALUE_WIDTH  PUT data.
- resp_valid  out  1  response valid.
- resp_ready  in  1  host accepts the response.
- resp_status  out  2  0=OK, 1=MISS, 2=FULL, 3=ERR.
- resp_value  out  VALUE_WIDTH  GET data.
- mem_write  out  1  storage write strobe.
- mem_select_by_index  out  1  index-addressed access.
- mem_delete  out  1  storage delete strobe.
- mem_key  out  KEY_WIDTH  key to storage.
- mem_value  out  VALUE_WIDTH  value to storage.
- mem_index  out  NUM_ENTRIES  one-hot slot select.
- mem_value_out  in  VALUE_WIDTH  storage read data.
- mem_index_out  in  NUM_ENTRIES  one-hot match from storage.
- mem_hit  in  1  storage key match.
- mem_used_entries  in  NUM_ENTRIES  occupied-slot mask.

Function
REQ-006 SHALL implement the FSM IDLE -> LOOKUP -> EXEC -> RESP -> IDLE, with exactly one request in flight.
REQ-007 req_ready SHALL be 1 only in IDLE; a handshake in cycle T SHALL latch op, key and value and enter LOOKUP at T+1.
REQ-008 In LOOKUP, the FSM SHALL drive mem_key with the latched key and mem_select_by_index=0, and SHALL register mem_hit, mem_index_out, mem_value_out and mem_used_entries.
REQ-009 In EXEC, the FSM SHALL decide the outcome:
- GET hit: OK with the stored value; GET miss: MISS.
- PUT hit: write to the matched index; PUT miss: write to the lowest-numbered free slot; if no slot is free: FULL and no write.
- DEL hit: pulse mem_delete with mem_index = the matched index; DEL miss: MISS.
REQ-010 mem_write and mem_delete SHALL be registered, glitch-free, single-cycle pulses, asserted only during EXEC, and never both asserted in the same cycle.
REQ-011 During a PUT write, the FSM SHALL drive mem_key and mem_value with the latched data and mem_select_by_index=0.
REQ-012 mem_index SHALL be one-hot during a pulse and all-zero otherwise.
REQ-013 A latched key of all zeros, or req_op=3, SHALL skip the storage access (no pulse) and respond ERR.
REQ-014 The response SHALL be presented in RESP (T+3 after acceptance).
REQ-015 resp_valid, resp_status and resp_value SHALL be held stable until resp_ready=1.
REQ-016 resp_value SHALL be 0 for any response other than GET OK.
REQ-017 The RESP handshake SHALL return the FSM to IDLE on the next cycle, so the minimum request period is 4 cycles plus response backpressure.
REQ-018 A PUT that finds exactly one free slot SHALL use it; a following PUT with a new key SHALL return FULL.

Reset
REQ-019 Asserting rst (at any time, including mid-request) SHALL force IDLE and drive every output to 0 except req_ready, which SHALL be 1 once rst deasserts.
REQ-020 A request interrupted by reset SHALL be dropped with no response and no storage pulse.

Configuration
REQ-021 With CACHE_CTRL_STATS_EN defined, the block SHALL add outputs hit_count and miss_count, each 16 bits, saturating at 0xFFFF and reset to 0.
REQ-022 hit_count SHALL increment on each GET OK response handshake; miss_count SHALL increment on each GET MISS response handshake.
REQ-023 Without CACHE_CTRL_STATS_EN, these ports and counters SHALL be absent and all other behaviour SHALL be unchanged.

Verification (NUM_ENTRIES=4, KEY_WIDTH=16, VALUE_WIDTH=64, storage model attached)
REQ-024 The bench SHALL cover:
- PUT key=0x0011 value=0xAA on an empty cache -> mem_write pulse with mem_index=0001 at T+2; resp OK at T+3.
- GET 0x0011 after that PUT -> resp OK, resp_value=0xAA; GET 0x0022 -> MISS, resp_value=0, no pulse.
- Four PUTs of distinct keys, then PUT 0x0099 -> FULL, no mem_write; PUT to an existing key -> OK, overwrites the matched index.
- DEL 0x0011 stored in slot 2 -> mem_delete pulse with mem_index=0100; repeat DEL -> MISS.
- PUT key=0x0000 and op=3 -> ERR, no pulse; hold resp_ready=0 for 5 cycles -> response held stable, req_ready=0.
- rst asserted during EXEC of a PUT -> no response, outputs 0, idle next cycle.
- With CACHE_CTRL_STATS_EN defined: 3 GET hits and 2 GET misses -> hit_count=3, miss_count=2.
